// File: rtl/fp_multiplier_seq_if.sv
// Handshake/bus bundle for the sequential single-precision multiplier.
//   start            request from controller, sampled only while busy=0
//   Input_1/Input_2  IEEE-754 single operands
//   busy             op in flight
//   done             one-cycle pulse, Multiplier_Float valid
//   Multiplier_Float packed result, held until the next done
//   overflow/underflow/invalid  status of the last completed op
`timescale 1ns/1ps
interface fp_multiplier_seq_if;
  logic        start;
  logic [31:0] Input_1;
  logic [31:0] Input_2;
  logic        busy;
  logic        done;
  logic [31:0] Multiplier_Float;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  modport master (
    output start, Input_1, Input_2,
    input  busy, done, Multiplier_Float, overflow, underflow, invalid
  );

  modport slave (
    input  start, Input_1, Input_2,
    output busy, done, Multiplier_Float, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754 single-precision multiplier (companion to the FP divider).
// Significands are multiplied by shift-and-add, BITS_PER_CYCLE multiplier bits
// per cycle, then normalised, rounded to nearest even and packed.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; aborts any op in flight without a done
//   bus    fp_multiplier_seq_if.slave (start/busy/done handshake, operands,
//          result and status flags; all outputs registered)
`timescale 1ns/1ps
module fp_multiplier_seq #(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  fp_multiplier_seq_if.slave   bus
);

  localparam int unsigned N     = 24 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_MULT,
    S_NORM,
    S_ROUND
  } state_t;

  state_t              state;
  logic [47:0]         acc;
  logic [47:0]         mcand_sh;
  logic [23:0]         mplier;
  logic [CNT_W-1:0]    cnt;
  logic signed [9:0]   exp_q;
  logic                sign_q;
  logic [22:0]         frac_q;
  logic                guard_q;
  logic                sticky_q;
  logic [31:0]         spec_res_q;
  logic                spec_inv_q;

  // Operand classification, evaluated on the live inputs at accept time
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        sign_in;
  logic        spec_hit;
  logic        spec_inv;
  logic [31:0] spec_res;

  always_comb begin
    ea       = bus.Input_1[30:23];
    eb       = bus.Input_2[30:23];
    sign_in  = bus.Input_1[31] ^ bus.Input_2[31];
    a_zero   = (ea == 8'h00);
    b_zero   = (eb == 8'h00);
    a_inf    = (ea == 8'hFF) && (bus.Input_1[22:0] == 23'h0);
    b_inf    = (eb == 8'hFF) && (bus.Input_2[22:0] == 23'h0);
    a_nan    = (ea == 8'hFF) && (bus.Input_1[22:0] != 23'h0);
    b_nan    = (eb == 8'hFF) && (bus.Input_2[22:0] != 23'h0);
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = {sign_in, 31'h0};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = {sign_in, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      spec_res = {sign_in, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Partial product for the current group of multiplier bits
  logic [47:0] pp;

  always_comb begin
    pp = '0;
    for (int b = 0; b < int'(BITS_PER_CYCLE); b++) begin
      if (mplier[b]) pp = pp + (mcand_sh << b);
    end
  end

  // Round-to-nearest-even on the normalised fraction
  logic              round_up;
  logic [23:0]       frac_sum;
  logic signed [9:0] exp_r;

  always_comb begin
    round_up = guard_q & (sticky_q | frac_q[0]);
    frac_sum = {1'b0, frac_q} + {23'h0, round_up};
    exp_r    = frac_sum[23] ? (exp_q + 10'sd1) : exp_q;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= S_IDLE;
      acc                  <= '0;
      mcand_sh             <= '0;
      mplier               <= '0;
      cnt                  <= '0;
      exp_q                <= '0;
      sign_q               <= 1'b0;
      frac_q               <= '0;
      guard_q              <= 1'b0;
      sticky_q             <= 1'b0;
      spec_res_q           <= '0;
      spec_inv_q           <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.Multiplier_Float <= '0;
      bus.overflow         <= 1'b0;
      bus.underflow        <= 1'b0;
      bus.invalid          <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy   <= 1'b1;
            sign_q     <= sign_in;
            spec_res_q <= spec_res;
            spec_inv_q <= spec_inv;
            acc        <= '0;
            cnt        <= '0;
            mcand_sh   <= {24'h0, 1'b1, bus.Input_1[22:0]};
            mplier     <= {1'b1, bus.Input_2[22:0]};
            exp_q      <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            state      <= spec_hit ? S_SPECIAL : S_MULT;
          end
        end
        S_SPECIAL: begin
          bus.Multiplier_Float <= spec_res_q;
          bus.overflow         <= 1'b0;
          bus.underflow        <= 1'b0;
          bus.invalid          <= spec_inv_q;
          bus.done             <= 1'b1;
          bus.busy             <= 1'b0;
          state                <= S_IDLE;
        end
        S_MULT: begin
          acc      <= acc + pp;
          mcand_sh <= mcand_sh << BITS_PER_CYCLE;
          mplier   <= mplier >> BITS_PER_CYCLE;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) state <= S_NORM;
        end
        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4)
          if (acc[47]) begin
            frac_q   <= acc[46:24];
            guard_q  <= acc[23];
            sticky_q <= |acc[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            frac_q   <= acc[45:23];
            guard_q  <= acc[22];
            sticky_q <= |acc[21:0];
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          bus.overflow  <= 1'b0;
          bus.underflow <= 1'b0;
          bus.invalid   <= 1'b0;
          if (exp_r >= 10'sd255) begin
            bus.Multiplier_Float <= {sign_q, 8'hFF, 23'h0};
            bus.overflow         <= 1'b1;
          end else if (exp_r <= 10'sd0) begin
            bus.Multiplier_Float <= {sign_q, 31'h0};
            bus.underflow        <= 1'b1;
          end else begin
            bus.Multiplier_Float <= {sign_q, exp_r[7:0], frac_sum[22:0]};
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Self-checking bench for fp_multiplier_seq: directed vectors, handshake and
// reset scenarios, and randomized operands checked against an arithmetic model.
`timescale 1ns/1ps
module tb_fp_multiplier_seq;

  localparam int unsigned BPC = 2;
  localparam int unsigned LAT = 24 / BPC + 2;

  logic clock = 1'b0;
  logic reset;

  fp_multiplier_seq_if bus ();

  fp_multiplier_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: exact integer product, then RNE via remainder comparison
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [2:0] f, output bit special);
    logic [7:0]         ea, eb;
    logic               s;
    bit                 az, bz, ai, bi, an, bn;
    longint unsigned    prod, q, rem, half;
    int                 e, sh;
    ea = a[30:23]; eb = b[30:23];
    s  = a[31] ^ b[31];
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0); bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0); bn = (eb == 255) && (b[22:0] != 0);
    f = 3'b000;
    special = 1'b1;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r = 32'h7FC0_0000; f = 3'b001;
    end else if (ai || bi) begin
      r = {s, 8'hFF, 23'h0};
    end else if (az || bz) begin
      r = {s, 31'h0};
    end else begin
      special = 1'b0;
      prod = (64'(a[22:0]) + 64'd8388608) * (64'(b[22:0]) + 64'd8388608);
      e = int'(ea) + int'(eb) - 127;
      if (prod >= (64'd1 << 47)) begin sh = 24; e++; end
      else sh = 23;
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 3'b100;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 3'b010;
      end else begin
        r = {s, 8'(e), q[22:0]};
      end
    end
  endtask

  function automatic logic [2:0] flags();
    return {bus.overflow, bus.underflow, bus.invalid};
  endfunction

  // Issue one op and wait (bounded) for done; samples #1 after edges
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [2:0] f, output int lat);
    @(negedge clock);
    bus.start = 1'b1; bus.Input_1 = a; bus.Input_2 = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("busy after accept", 32'(bus.busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clock); #1; lat++;
    end while (!bus.done && lat < 40);
    if (!bus.done) check("done timeout", 32'(bus.done), 32'd1);
    r = bus.Multiplier_Float;
    f = flags();
    check("busy at done", 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    int          sel;
    logic [31:0] v;
    sel = int'($urandom_range(0, 9));
    v   = $urandom;
    if (sel < 7) v[30:23] = 8'($urandom_range(60, 195));
    if (sel == 3) v[11:0] = 12'h0;
    if (sel == 7) v[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
    return v;
  endfunction

  logic [31:0] da [10] = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                          32'h00800000, 32'h7F800000, 32'hFF800000, 32'h7FA00001, 32'h80000000};
  logic [31:0] db [10] = '{32'h40000000, 32'h3F000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000,
                          32'h00800000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000};
  logic [31:0] dr [10] = '{32'h40400000, 32'hBFC00000, 32'h3FC00002, 32'h3F800002, 32'h7F800000,
                          32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
  logic [2:0]  df [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                          3'b010, 3'b001, 3'b000, 3'b001, 3'b000};
  int          dl [10] = '{LAT, LAT, LAT, LAT, LAT, LAT, 1, 1, 1, 1};

  initial begin
    logic [31:0] r, er;
    logic [2:0]  f, ef;
    int          lat;
    bit          sp, seen;

    bus.start = 1'b0; bus.Input_1 = '0; bus.Input_2 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset busy",   32'(bus.busy), 32'd0);
    check("reset done",   32'(bus.done), 32'd0);
    check("reset result", bus.Multiplier_Float, 32'd0);
    check("reset flags",  32'(flags()), 32'd0);

    // Directed vectors, issued back-to-back on the done cycle
    for (int i = 0; i < 10; i++) begin
      do_op(da[i], db[i], r, f, lat);
      check($sformatf("dir%0d result", i), r, dr[i]);
      check($sformatf("dir%0d flags", i), 32'(f), 32'(df[i]));
      check($sformatf("dir%0d latency", i), 32'(lat), 32'(dl[i]));
    end
    @(posedge clock); #1;
    check("done one cycle", 32'(bus.done), 32'd0);
    check("result held", bus.Multiplier_Float, 32'h80000000);

    // start while busy is ignored
    @(negedge clock);
    bus.start = 1'b1; bus.Input_1 = 32'h3FC00000; bus.Input_2 = 32'h40000000;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.start = 1'b1; bus.Input_1 = 32'h40400000; bus.Input_2 = 32'h40400000;
    @(posedge clock); #1 bus.start = 1'b0;
    lat = 4;
    do begin
      @(posedge clock); #1; lat++;
    end while (!bus.done && lat < 40);
    check("busy-ignore result", bus.Multiplier_Float, 32'h40400000);
    check("busy-ignore latency", 32'(lat), 32'(LAT));
    seen = 1'b0;
    repeat (20) begin @(posedge clock); #1; if (bus.done) seen = 1'b1; end
    check("busy-ignore no extra done", 32'(seen), 32'd0);

    // Reset mid-operation aborts with no done
    @(negedge clock);
    bus.start = 1'b1; bus.Input_1 = 32'hC0400000; bus.Input_2 = 32'h3F000000;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check("abort busy",   32'(bus.busy), 32'd0);
    check("abort result", bus.Multiplier_Float, 32'd0);
    check("abort flags",  32'(flags()), 32'd0);
    seen = bus.done;
    repeat (20) begin @(posedge clock); #1; if (bus.done) seen = 1'b1; end
    check("abort no done", 32'(seen), 32'd0);
    do_op(32'hC0400000, 32'h3F000000, r, f, lat);
    check("after reset result",  r, 32'hBFC00000);
    check("after reset latency", 32'(lat), 32'(LAT));

    // Randomized operands against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = rand_fp();
      b = rand_fp();
      model(a, b, er, ef, sp);
      do_op(a, b, r, f, lat);
      check($sformatf("rnd%0d %08h*%08h result", i, a, b), r, er);
      check($sformatf("rnd%0d flags", i), 32'(f), 32'(ef));
      check($sformatf("rnd%0d latency", i), 32'(lat), sp ? 32'd1 : 32'(LAT));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
